// File: rtl/tlu_trigger_logic_if.sv
// Bundle of beam-input, configuration, DUT-ready and record-FIFO signals for tlu_trigger_logic.
interface tlu_trigger_logic_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 6,
    parameter int unsigned LEW   = 8,
    parameter int unsigned TSW   = 64
);
    logic                  start;
    logic [N_IN-1:0]       valid;
    logic [N_IN*LEW-1:0]   le_rel;
    logic                  test_pulse;
    logic [N_IN-1:0]       conf_en_input;
    logic                  conf_mode;
    logic [LEW-1:0]        conf_max_le_dist;
    logic [7:0]            conf_holdoff;
    logic [N_OUT-1:0]      conf_en_output;
    logic [N_OUT-1:0]      ready;
    logic                  trig;
    logic [LEW-1:0]        trig_le;
    logic [31:0]           trig_id;
    logic [TSW-1:0]        time_stamp;
    logic [15:0]           skip_cnt;
    logic [7:0]            lost_cnt;
    logic                  fifo_read;
    logic                  fifo_empty;
    logic [31:0]           fifo_data;

    modport master (
        output start, valid, le_rel, test_pulse, conf_en_input, conf_mode,
               conf_max_le_dist, conf_holdoff, conf_en_output, ready, fifo_read,
        input  trig, trig_le, trig_id, time_stamp, skip_cnt, lost_cnt,
               fifo_empty, fifo_data
    );

    modport slave (
        input  start, valid, le_rel, test_pulse, conf_en_input, conf_mode,
               conf_max_le_dist, conf_holdoff, conf_en_output, ready, fifo_read,
        output trig, trig_le, trig_id, time_stamp, skip_cnt, lost_cnt,
               fifo_empty, fifo_data
    );
endinterface

// File: rtl/tlu_trigger_logic.sv
// TLU trigger decision core: coincidence, edge detect, hold-off/READY gating,
// trigger ID/timestamp/counters and a 2-word-per-trigger record FIFO.
module tlu_trigger_logic #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 6,
    parameter int unsigned LEW        = 8,
    parameter int unsigned TSW        = 64,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk40,
    input  logic               rst,
    tlu_trigger_logic_if.slave bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] S_ARMED   = 1'b0;
    localparam logic [0:0] S_HOLDOFF = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ID   = 2'd1;
    localparam logic [1:0] W_TS   = 2'd2;

    // ---------------------------------------------------------------
    // Coincidence over the enabled, valid channels
    logic [N_IN-1:0] m_c;
    logic [LEW-1:0]  max_le_c;
    logic [LEW-1:0]  min_le_c;
    logic            coin_c;

    always_comb begin
        m_c      = bus.valid & bus.conf_en_input;
        max_le_c = '0;
        min_le_c = '1;
        coin_c   = 1'b0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (m_c[k]) begin
                if (bus.le_rel[k*LEW +: LEW] > max_le_c) max_le_c = bus.le_rel[k*LEW +: LEW];
                if (bus.le_rel[k*LEW +: LEW] < min_le_c) min_le_c = bus.le_rel[k*LEW +: LEW];
            end
        end
        if (bus.conf_mode) begin
            coin_c = |m_c;
        end else begin
            coin_c = (m_c == bus.conf_en_input) && (|bus.conf_en_input) &&
                     ((max_le_c - min_le_c) < bus.conf_max_le_dist);
        end
        coin_c = coin_c | bus.test_pulse;
    end

    // Registered coincidence, its delayed copy and the LE that travels with it
    logic           coin_ff;
    logic           coin_ff_d;
    logic [LEW-1:0] le_ff;
    logic           edge_c;

    always_ff @(posedge clk40) begin
        if (rst) begin
            coin_ff   <= 1'b0;
            coin_ff_d <= 1'b0;
            le_ff     <= '0;
        end else begin
            coin_ff   <= coin_c;
            coin_ff_d <= coin_ff;
            le_ff     <= max_le_c;
        end
    end

    assign edge_c = coin_ff & ~coin_ff_d;

    // ---------------------------------------------------------------
    // Arm/hold-off state machine
    logic [0:0] state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       accept_c;
    logic       skip_c;
    logic       dut_ready_c;

    assign dut_ready_c = &(bus.ready | ~bus.conf_en_output);

    always_ff @(posedge clk40) begin
        if (rst) begin
            state_q <= S_ARMED;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        accept_c = 1'b0;
        skip_c   = 1'b0;
        case (state_q)
            S_ARMED: begin
                if (edge_c) begin
                    if (dut_ready_c) begin
                        accept_c = 1'b1;
                        hold_d   = bus.conf_holdoff;
                        if (bus.conf_holdoff != 8'd0) state_d = S_HOLDOFF;
                    end else begin
                        skip_c = 1'b1;
                    end
                end
            end
            S_HOLDOFF: begin
                skip_c = edge_c;
                hold_d = hold_q - 8'd1;
                if (hold_q <= 8'd1) begin
                    state_d = S_ARMED;
                    hold_d  = 8'd0;
                end
            end
            default: begin
                state_d = S_ARMED;
                hold_d  = 8'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Record FIFO bookkeeping (needed by the lost-record decision below)
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [31:0]   mem [FIFO_DEPTH];
    logic          pop_c;
    logic          push_c;
    logic [31:0]   push_data_c;
    logic [CW-1:0] pending_c;
    logic [CW-1:0] free_c;
    logic          rec_ok_c;
    logic          lost_c;
    logic [1:0]    wr_state_q, wr_state_d;

    logic           trig_q;
    logic [LEW-1:0] trig_le_q;
    logic [31:0]    trig_id_q;
    logic [TSW-1:0] ts_q;
    logic [15:0]    skip_q;
    logic [7:0]     lost_q;

    assign pop_c = bus.fifo_read && (count_q != '0);

    // Words already promised to the FIFO but not yet pushed
    always_comb begin
        pending_c = '0;
        case (wr_state_q)
            W_ID:    pending_c = CW'(2);
            W_TS:    pending_c = CW'(1);
            default: pending_c = '0;
        endcase
    end

    assign free_c   = CW'(FIFO_DEPTH) - count_q - pending_c + CW'(pop_c);
    assign rec_ok_c = trig_q && (free_c >= CW'(2));
    assign lost_c   = trig_q && !rec_ok_c;

    // ---------------------------------------------------------------
    // Trigger outputs, timestamp and counters
    always_ff @(posedge clk40) begin
        if (rst) begin
            trig_q    <= 1'b0;
            trig_le_q <= '0;
            trig_id_q <= 32'd0;
            ts_q      <= '0;
            skip_q    <= 16'd0;
            lost_q    <= 8'd0;
        end else begin
            trig_q <= accept_c;
            if (accept_c) trig_le_q <= le_ff;
            if (bus.start) begin
                ts_q      <= '0;
                trig_id_q <= 32'd0;
                skip_q    <= 16'd0;
                lost_q    <= 8'd0;
            end else begin
                if (ts_q != '1)                        ts_q      <= ts_q + TSW'(1);
                if (trig_q && (trig_id_q != 32'hFFFF_FFFF)) trig_id_q <= trig_id_q + 32'd1;
                if (skip_c && (skip_q != 16'hFFFF))    skip_q    <= skip_q + 16'd1;
                if (lost_c && (lost_q != 8'hFF))       lost_q    <= lost_q + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Record writer: ID word then timestamp word, back-to-back records allowed
    logic [30:0] rec_id_q;
    logic [30:0] rec_ts_q;

    always_ff @(posedge clk40) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rec_id_q   <= 31'd0;
            rec_ts_q   <= 31'd0;
        end else begin
            wr_state_q <= wr_state_d;
            if (rec_ok_c) begin
                rec_id_q <= trig_id_q[30:0];
                rec_ts_q <= ts_q[30:0];
            end
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        push_c      = 1'b0;
        push_data_c = 32'd0;
        case (wr_state_q)
            W_IDLE: begin
                if (rec_ok_c) wr_state_d = W_ID;
            end
            W_ID: begin
                push_c      = 1'b1;
                push_data_c = {1'b1, rec_id_q};
                wr_state_d  = W_TS;
            end
            W_TS: begin
                push_c      = 1'b1;
                push_data_c = {1'b0, rec_ts_q};
                wr_state_d  = rec_ok_c ? W_ID : W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // First-word-fall-through storage
    always_ff @(posedge clk40) begin
        if (push_c) mem[wr_ptr_q] <= push_data_c;
    end

    always_ff @(posedge clk40) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    assign bus.trig       = trig_q;
    assign bus.trig_le    = trig_le_q;
    assign bus.trig_id    = trig_id_q;
    assign bus.time_stamp = ts_q;
    assign bus.skip_cnt   = skip_q;
    assign bus.lost_cnt   = lost_q;
    assign bus.fifo_empty = (count_q == '0);
    assign bus.fifo_data  = (count_q == '0) ? 32'd0 : mem[rd_ptr_q];

endmodule
